fb_pingpong_ctrl: RTL and testbench

// Double-buffered frame-store controller between the 2:1 downscaler write stream and a downstream frame reader.

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_skid_fifo.sv | 43 ++++
 rtl/fb_pingpong_ctrl.sv | 157 +++++++++++++++
 tb/tb_fb_pingpong_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and defaults for the ping-pong frame-store controller.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2
  } rd_state_e;

  localparam int FB_H_PIXELS   = 384;
  localparam int FB_V_PIXELS   = 256;
  localparam int FB_FRAME_SIZE = FB_H_PIXELS * FB_V_PIXELS;
  localparam int FB_CNT_W      = $clog2(FB_FRAME_SIZE);
  localparam int FB_ADDR_W     = FB_CNT_W + 1;

  localparam logic [7:0] DROP_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == DROP_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fb_skid_fifo.sv
// Two-entry skid FIFO holding read data plus its end-of-frame tag.
module fb_skid_fifo #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/fb_pingpong_ctrl.sv
// Double-buffered frame store: writer fills one bank, reader streams the
// other, both sharing one single-port RAM with writes taking priority.
module fb_pingpong_ctrl
  import fb_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int H_PIXELS   = FB_H_PIXELS,
  parameter  int V_PIXELS   = FB_V_PIXELS,
  localparam int FRAME_SIZE = H_PIXELS * V_PIXELS,
  localparam int CNT_W      = $clog2(FRAME_SIZE),
  localparam int ADDR_W     = CNT_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_frame_start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_start,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              rd_busy,
  output logic              frame_avail,
  output logic [7:0]        drop_cnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  rd_state_e state;
  rd_state_e state_nxt;

  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] wr_idx;
  logic [CNT_W:0]   rd_cnt;
  logic             wbank;
  logic             wbank_nxt;
  logic             rbank;
  logic             eof;
  logic             go_stream;
  logic             issue;
  logic             pop;
  logic             rd_pend;
  logic             rd_pend_last;
  logic [1:0]       fifo_cnt;
  logic [DATA_W:0]  head;

  assign wr_idx    = wr_frame_start ? '0 : wr_cnt;
  assign eof       = wr_valid && (wr_idx == CNT_W'(FRAME_SIZE - 1));
  assign wbank_nxt = (eof && state != ST_STREAM) ? ~wbank : wbank;
  assign go_stream = (state_nxt == ST_STREAM) && (state != ST_STREAM);
  assign pop       = rd_valid && rd_ready;

  // Room counts the pop happening this cycle so a steady stream has no bubble.
  assign issue = (state == ST_STREAM) && !wr_valid
              && (rd_cnt < (CNT_W + 1)'(FRAME_SIZE))
              && (({1'b0, fifo_cnt} + {2'b0, rd_pend})
                  < (3'd2 + {2'b0, pop}));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (rd_start) begin
          state_nxt = frame_avail ? ST_STREAM : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (frame_avail) begin
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (pop && rd_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_busy   = (state != ST_IDLE);
    ram_we    = wr_valid;
    ram_wdata = '0;
    ram_addr  = '0;
    if (wr_valid) begin
      ram_addr  = {wbank, wr_idx};
      ram_wdata = wr_data;
    end else if (issue) begin
      ram_addr = {rbank, rd_cnt[CNT_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt       <= '0;
      wbank        <= 1'b0;
      rbank        <= 1'b0;
      frame_avail  <= 1'b0;
      drop_cnt     <= 8'd0;
      rd_cnt       <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      if (wr_frame_start || wr_valid) begin
        wr_cnt <= (!wr_valid || eof) ? '0 : wr_idx + 1'b1;
      end
      wbank <= wbank_nxt;
      if (go_stream) begin
        frame_avail <= 1'b0;
      end else if (eof && state != ST_STREAM) begin
        frame_avail <= 1'b1;
      end
      if (eof && (state == ST_STREAM || frame_avail)) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
      // A frame completing on the entry cycle is the freshest: read it.
      if (go_stream) begin
        rbank  <= ~wbank_nxt;
        rd_cnt <= '0;
      end else if (issue) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      rd_pend      <= issue;
      rd_pend_last <= issue
                   && (rd_cnt == (CNT_W + 1)'(FRAME_SIZE - 1));
    end
  end

  fb_skid_fifo #(
    .W(DATA_W + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_pend),
    .push_data({ram_rdata, rd_pend_last}),
    .pop      (pop),
    .head     (head),
    .count    (fifo_cnt)
  );

  assign rd_valid = (fifo_cnt != 2'd0);
  assign rd_data  = rd_valid ? head[DATA_W:1] : '0;
  assign rd_last  = rd_valid && head[0];

endmodule

// File: tb/tb_fb_pingpong_ctrl.sv
// Bench for fb_pingpong_ctrl with an 8-pixel frame and a 1-cycle RAM model.
module tb_fb_pingpong_ctrl;

  localparam int DW = 8;
  localparam int FS = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_frame_start;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          rd_start;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          rd_busy;
  logic          frame_avail;
  logic [7:0]    drop_cnt;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  fb_pingpong_ctrl #(
    .DATA_W  (DW),
    .H_PIXELS(4),
    .V_PIXELS(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_frame_start(wr_frame_start),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .rd_start      (rd_start),
    .rd_ready      (rd_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_last       (rd_last),
    .rd_busy       (rd_busy),
    .frame_avail   (frame_avail),
    .drop_cnt      (drop_cnt),
    .ram_addr      (ram_addr),
    .ram_we        (ram_we),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  typedef struct {
    logic          fs;
    logic          wv;
    logic [DW-1:0] wd;
    logic          rs;
    logic          rr;
    logic          we;
    logic          ca;
    logic [AW-1:0] addr;
    logic          avail;
    logic          busy;
    logic [7:0]    drop;
    logic          valid;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  logic          stall_prev = 1'b0;
  logic [DW-1:0] data_prev;
  exp_t          e;

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        chk("hold_valid", 32'(rd_valid), 32'd1);
        chk("hold_data", 32'(rd_data), 32'(data_prev));
      end
      if (rd_valid && rd_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_pixel actual=%0h required=none", rd_data);
        end else begin
          e = sb.pop_front();
          chk("rd_data", 32'(rd_data), 32'(e.d));
          chk("rd_last", 32'(rd_last), 32'(e.l));
        end
      end
      stall_prev = rd_valid && !rd_ready;
      data_prev  = rd_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic fs, input logic wv, input logic [7:0] wd,
                     input logic rs, input logic rr, input logic we,
                     input logic ca, input logic [3:0] addr,
                     input logic avail, input logic busy,
                     input logic [7:0] drop, input logic valid);
    vec_t v;
    v = '{fs, wv, wd, rs, rr, we, ca, addr, avail, busy, drop, valid};
    vt.push_back(v);
  endtask

  task automatic push_frame(input logic [7:0] base);
    for (int i = 0; i < FS; i++) begin
      sb.push_back('{base + 8'(i), i == FS - 1});
    end
  endtask

  task automatic write_frame(input logic [7:0] base);
    for (int i = 0; i < FS; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int limit);
    int k;
    k = 0;
    while ((sb.size() != 0 || rd_busy) && k < limit) begin
      tick();
      k++;
    end
    if (k >= limit) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d required=0", nm, sb.size());
    end
  endtask

  task automatic stream(input logic [7:0] base, input bit stall);
    push_frame(base);
    rd_start = 1'b1;
    rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0 && !rd_busy) break;
      rd_ready = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      tick();
    end
    rd_ready = 1'b1;
    wait_done("stream", 4);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    wr_frame_start = 1'b0;
    wr_valid = 1'b0;
    wr_data = '0;
    rd_start = 1'b0;
    rd_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    //  fs wv wd     rs rr we ca addr avail busy drop valid
    add(0, 0, 8'h00, 0, 0, 0, 0, 4'd0, 0, 0, 8'd0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 1, 8'hA0 + 8'(i), 0, 0, 1, 1, 4'(i), 0, 0, 8'd0, 0);
    add(1, 1, 8'h10, 0, 0, 1, 1, 4'd0, 0, 0, 8'd0, 0);
    for (int i = 1; i < FS; i++)
      add(0, 1, 8'h10 + 8'(i), 0, 0, 1, 1, 4'(i), 0, 0, 8'd0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 0, 4'd0, 1, 0, 8'd0, 0);
    add(0, 0, 8'h00, 1, 1, 0, 0, 4'd0, 1, 0, 8'd0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 1, 4'd0, 0, 1, 8'd0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 1, 4'd1, 0, 1, 8'd0, 0);
    for (int i = 2; i < FS; i++)
      add(0, 0, 8'h00, 0, 1, 0, 1, 4'(i), 0, 1, 8'd0, 1);
    add(0, 0, 8'h00, 0, 1, 0, 0, 4'd0, 0, 1, 8'd0, 1);
    add(0, 0, 8'h00, 0, 1, 0, 0, 4'd0, 0, 1, 8'd0, 1);
    add(0, 0, 8'h00, 0, 1, 0, 0, 4'd0, 0, 0, 8'd0, 0);

    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_last", 32'(rd_last), 32'd0);
    push_frame(8'h10);
    foreach (vt[i]) begin
      wr_frame_start = vt[i].fs;
      wr_valid       = vt[i].wv;
      wr_data        = vt[i].wd;
      rd_start       = vt[i].rs;
      rd_ready       = vt[i].rr;
      @(negedge clk);
      chk($sformatf("v%0d_we", i), 32'(ram_we), 32'(vt[i].we));
      if (vt[i].ca)
        chk($sformatf("v%0d_addr", i), 32'(ram_addr), 32'(vt[i].addr));
      if (vt[i].we)
        chk($sformatf("v%0d_wdata", i), 32'(ram_wdata), 32'(vt[i].wd));
      chk($sformatf("v%0d_avail", i), 32'(frame_avail), 32'(vt[i].avail));
      chk($sformatf("v%0d_busy", i), 32'(rd_busy), 32'(vt[i].busy));
      chk($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(vt[i].drop));
      chk($sformatf("v%0d_valid", i), 32'(rd_valid), 32'(vt[i].valid));
      tick();
    end
    wr_frame_start = 1'b0;
    rd_start = 1'b0;
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    write_frame(8'h20);
    chk("t2_avail", 32'(frame_avail), 32'd1);
    stream(8'h20, 1'b1);

    write_frame(8'h30);
    push_frame(8'h30);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    rd_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      wr_valid = (k < 16) && (k % 2 == 0);
      wr_data  = 8'h40 + 8'(k / 2);
      @(negedge clk);
      if (wr_valid) begin
        chk("t3_we", 32'(ram_we), 32'd1);
        chk("t3_waddr", 32'(ram_addr), 32'(8 + k / 2));
      end
      tick();
      if (k >= 15 && sb.size() == 0 && !rd_busy) break;
    end
    wr_valid = 1'b0;
    wait_done("t3", 4);
    chk("t3_drop", 32'(drop_cnt), 32'd1);
    chk("t3_avail", 32'(frame_avail), 32'd0);
    for (int i = 0; i < FS; i++)
      chk("t3_ram", 32'(mem[8 + i]), 32'(8'h40 + 8'(i)));

    write_frame(8'h50);
    chk("t4_avail", 32'(frame_avail), 32'd1);
    chk("t4_drop_a", 32'(drop_cnt), 32'd1);
    write_frame(8'h60);
    chk("t4_drop_b", 32'(drop_cnt), 32'd2);
    stream(8'h60, 1'b0);

    write_frame(8'h70);
    push_frame(8'h70);
    rd_start = 1'b1;
    rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int k = 0; k < 50 && sb.size() > 4; k++) tick();
    chk("t6_popped", 32'(sb.size()), 32'd4);
    rst = 1'b1;
    rd_ready = 1'b0;
    sb.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", 32'(rd_valid), 32'd0);
    chk("t6_busy", 32'(rd_busy), 32'd0);
    chk("t6_avail", 32'(frame_avail), 32'd0);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    tick();
    write_frame(8'h80);
    stream(8'h80, 1'b0);
    chk("t6_drop_end", 32'(drop_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
